// File: rtl/vm_pkg.sv
// ============================================================================
// Module   : vm_pkg
// Purpose  : Channel indices and timing defaults for the vending-machine front end.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vm_pkg;

  localparam int CH_COIN   = 0;
  localparam int CH_ACCEPT = 1;
  localparam int CH_BTNC   = 2;
  localparam int CH_BTND   = 3;

  localparam int N_CH_DEFAULT         = 4;
  localparam int DB_CYCLES_DEFAULT    = 16;
  localparam int STUCK_CYCLES_DEFAULT = 4096;

endpackage

`default_nettype wire

// File: rtl/vm_debounce_ch.sv
// ============================================================================
// Module   : vm_debounce_ch
// Purpose  : One input channel: 2-FF sync, counter debounce, rise pulse, stuck flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vm_debounce_ch
  import vm_pkg::*;
#(
  parameter int DB_CYCLES    = DB_CYCLES_DEFAULT,
  parameter int STUCK_CYCLES = STUCK_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic stuck
);

  localparam int c_DB_W   = $clog2(DB_CYCLES);
  localparam int c_HOLD_W = $clog2(STUCK_CYCLES + 1);

  localparam logic [c_DB_W-1:0]   c_DB_LAST  = c_DB_W'(DB_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(STUCK_CYCLES);

  logic                r_s1;
  logic                r_s2;
  logic [c_DB_W-1:0]   r_db_cnt;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic                r_level;
  logic                r_pulse;
  logic                r_stuck;

  logic                w_differ;
  logic                w_flip;
  logic                w_fall;
  logic [c_HOLD_W-1:0] w_hold_inc;

  assign w_differ   = (r_s2 != r_level);
  assign w_flip     = w_differ && (r_db_cnt == c_DB_LAST);
  assign w_fall     = w_flip && !r_s2;
  assign w_hold_inc = r_hold_cnt + c_HOLD_W'(1);

  // Synchroniser keeps running while ena is low so no metastable sample is consumed later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_level    <= 1'b0;
      r_pulse    <= 1'b0;
      r_stuck    <= 1'b0;
    end else if (!ena) begin
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_flip && r_s2;

      if (!w_differ) begin
        r_db_cnt <= '0;
      end else if (w_flip) begin
        r_level  <= r_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + c_DB_W'(1);
      end

      // Clearing on the falling flip lets stuck drop on the same edge as level.
      if (!r_level || w_fall) begin
        r_hold_cnt <= '0;
        r_stuck    <= 1'b0;
      end else if (r_hold_cnt != c_HOLD_MAX) begin
        r_hold_cnt <= w_hold_inc;
        if (w_hold_inc == c_HOLD_MAX) begin
          r_stuck <= 1'b1;
        end
      end
    end
  end

  assign level = r_level;
  assign pulse = r_pulse;
  assign stuck = r_stuck;

endmodule

`default_nettype wire

// File: rtl/vm_input_conditioner.sv
// ============================================================================
// Module   : vm_input_conditioner
// Purpose  : Conditions raw coin/accept/button pads into clean levels and one-shot events.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vm_input_conditioner
  import vm_pkg::*;
#(
  parameter int N_CH         = N_CH_DEFAULT,
  parameter int DB_CYCLES    = DB_CYCLES_DEFAULT,
  parameter int STUCK_CYCLES = STUCK_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_pulse,
  output logic [N_CH-1:0] stuck
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    vm_debounce_ch #(
      .DB_CYCLES    (DB_CYCLES),
      .STUCK_CYCLES (STUCK_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .raw   (btn_raw[g]),
      .level (btn_level[g]),
      .pulse (btn_pulse[g]),
      .stuck (stuck[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_vm_input_conditioner.sv
// ============================================================================
// Module   : tb_vm_input_conditioner
// Purpose  : Directed stimulus with a per-cycle behavioural model and literal checks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vm_input_conditioner;

  localparam int N    = 4;
  localparam int DB   = 4;
  localparam int STK  = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;
  logic [N-1:0] stuck;

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_pulse = '0, m_stuck = '0;
  int           m_run  [N];
  int           m_hold [N];

  vm_input_conditioner #(
    .N_CH         (N),
    .DB_CYCLES    (DB),
    .STUCK_CYCLES (STK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .stuck     (stuck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: level flips after DB consecutive enabled cycles of a differing synchronised
  // value; stuck once level has been 1 for STK enabled cycles.
  task automatic cycle();
    logic [N-1:0] nl, np, ns;
    @(posedge clk);
    #1;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0; m_stuck = '0;
      for (int c = 0; c < N; c++) begin
        m_run[c]  = 0;
        m_hold[c] = 0;
      end
    end else begin
      nl = m_lvl; np = '0; ns = m_stuck;
      if (ena) begin
        for (int c = 0; c < N; c++) begin
          bit fell;
          fell = 1'b0;
          if (m_s2[c] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == DB) begin
              nl[c]    = m_s2[c];
              np[c]    = m_s2[c];
              fell     = !m_s2[c];
              m_run[c] = 0;
            end
          end else begin
            m_run[c] = 0;
          end
          if (!m_lvl[c] || fell) begin
            m_hold[c] = 0;
            ns[c]     = 1'b0;
          end else begin
            m_hold[c]++;
            ns[c] = (m_hold[c] >= STK);
          end
        end
      end
      m_s2 = m_s1; m_s1 = btn_raw;
      m_lvl = nl; m_pulse = np; m_stuck = ns;
    end
    chk("model level", btn_level, m_lvl);
    chk("model pulse", btn_pulse, m_pulse);
    chk("model stuck", stuck, m_stuck);
  endtask

  initial begin
    int cnt, pe, p0, p2, rise_e, stuck_e, fall_e, sfall_e;
    logic [N-1:0] seen;

    for (int c = 0; c < N; c++) begin
      m_run[c]  = 0;
      m_hold[c] = 0;
    end

    // 1. reset with all inputs high
    rst = 1'b1; ena = 1'b1; btn_raw = 4'hF;
    repeat (3) begin
      cycle();
      chk("reset outputs", btn_level | btn_pulse | stuck, 4'h0);
    end
    rst = 1'b0; btn_raw = 4'h0;
    cycle();
    chk("first after reset", btn_level | btn_pulse | stuck, 4'h0);
    repeat (3) cycle();

    // 2. latency of a clean press on channel 0
    btn_raw = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (k == 4) chk("t2 level before edge 5", btn_level, 4'b0000);
      if (k == 5) begin
        chk("t2 level edge 5", btn_level, 4'b0001);
        chk("t2 pulse edge 5", btn_pulse, 4'b0001);
      end
      if (k == 6) chk("t2 pulse edge 6", btn_pulse, 4'b0000);
    end
    btn_raw = 4'b0000;
    repeat (8) cycle();
    chk("t2 released", btn_level, 4'b0000);

    // 3. short glitch on channel 1
    seen = '0;
    btn_raw = 4'b0010;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) btn_raw = 4'b0000;
      cycle();
      seen |= btn_level | btn_pulse;
    end
    chk("t3 glitch ignored", seen, 4'b0000);

    // 4. bouncing press on channel 2
    cnt = 0; pe = -1;
    for (int k = 0; k < 16; k++) begin
      btn_raw[2] = (k < 5) ? ((k % 2) == 0) : 1'b1;
      cycle();
      if (btn_pulse[2]) begin
        cnt++;
        pe = k;
      end
    end
    chk("t4 pulse count", 4'(cnt), 4'd1);
    chk("t4 pulse edge", 4'(pe), 4'd9);
    btn_raw = 4'b0000;
    repeat (8) cycle();

    // 5. stuck detection on channel 3
    rise_e = -1; stuck_e = -1; fall_e = -1; sfall_e = -1;
    for (int k = 0; k < 52; k++) begin
      btn_raw = (k < 40) ? 4'b1000 : 4'b0000;
      cycle();
      if (rise_e < 0 && btn_level[3]) rise_e = k;
      if (stuck_e < 0 && stuck[3]) stuck_e = k;
      if (rise_e >= 0 && fall_e < 0 && !btn_level[3]) fall_e = k;
      if (stuck_e >= 0 && sfall_e < 0 && !stuck[3]) sfall_e = k;
    end
    chk("t5 rise edge", 4'(rise_e), 4'd5);
    chk("t5 stuck delay", 8'(stuck_e - rise_e), 8'd32);
    chk("t5 fall edge", 8'(fall_e), 8'd45);
    chk("t5 stuck clears with level", 8'(sfall_e), 8'(fall_e));

    // 6a. two channels together with ena dropped mid-count
    p0 = -1; p2 = -1;
    btn_raw = 4'b0101;
    for (int k = 0; k < 13; k++) begin
      ena = !(k == 3 || k == 4);
      cycle();
      if (p0 < 0 && btn_pulse[0]) p0 = k;
      if (p2 < 0 && btn_pulse[2]) p2 = k;
      if (k == 7) chk("t6 joint pulse", btn_pulse, 4'b0101);
    end
    chk("t6 pulse0 edge", 4'(p0), 4'd7);
    chk("t6 pulse2 edge", 4'(p2), 4'd7);
    ena = 1'b1;
    btn_raw = 4'b0000;
    repeat (8) cycle();

    // 6b. reset mid-count discards progress
    seen = '0;
    btn_raw = 4'b0101;
    repeat (3) cycle();
    rst = 1'b1; btn_raw = 4'b0000;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      seen |= btn_level | btn_pulse;
    end
    chk("t6 reset mid-count", seen, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
